uart_cmd_ctrl: RTL

Frame-level controller sitting between the UART byte interface (`uart_core` rx/tx byte handshakes) and the on-chip register/memory bus. Parses host command frames from received bytes, issues a single bus read or write per frame, and sequences the response bytes back through the UART transmitter. It is the only master of the UART TX byte port and the host's sole path into the register bus.

---
 rtl/uart_cmd_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses UART command frames into single bus reads/writes and returns the response bytes.
module uart_cmd_ctrl #(
  parameter int ADDR_BYTES  = 2,
  parameter int DATA_BYTES  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic                    bus_ack,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    busy,
  output logic                    err
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int CW = $clog2((ADDR_BYTES > DATA_BYTES ? ADDR_BYTES : DATA_BYTES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, WDATA = 3'd2, BUS = 3'd3, RESP = 3'd4;
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt, rlen;
  logic [TW-1:0] tmr;
  logic [DW-1:0] rbuf;
  logic opc_ok, addr_last, data_last, tmo, tx_hs, tx_done;
  always_comb begin
    opc_ok = rx_data == 8'h57 || rx_data == 8'h52;
    addr_last = cnt == CW'(ADDR_BYTES - 1);
    data_last = cnt == CW'(DATA_BYTES - 1);
    tmo = (state == ADDR || state == WDATA) && !rx_valid && tmr == TW'(TIMEOUT_CYC - 1);
    tx_hs = tx_valid && tx_ready;
    tx_done = tx_hs && cnt == rlen - CW'(1);
    state_n = state == IDLE  ? (rx_valid ? (opc_ok ? ADDR : RESP) : IDLE) :
              state == ADDR  ? (rx_valid ? (addr_last ? (bus_we ? WDATA : BUS) : ADDR) : tmo ? IDLE : ADDR) :
              state == WDATA ? (rx_valid ? (data_last ? BUS : WDATA) : tmo ? IDLE : WDATA) :
              state == BUS   ? (bus_ack ? RESP : BUS) :
              state == RESP  ? (tx_done ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      err <= 1'b0;
      tmr <= '0;
      cnt <= '0;
      rlen <= '0;
      rbuf <= '0;
      tx_data <= 8'h00;
      tx_valid <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      err <= (state == IDLE && rx_valid && !opc_ok) || ((state == BUS || state == RESP) && rx_valid) || tmo;
      tmr <= rx_valid ? '0 : tmr + TW'(1);
      cnt <= state_n != state ? '0 : ((state == ADDR || state == WDATA) && rx_valid) || tx_hs ? cnt + CW'(1) : cnt;
      if (state == IDLE && rx_valid) begin
        bus_we <= rx_data == 8'h57;
        if (!opc_ok) begin
          tx_data <= 8'h45;
          tx_valid <= 1'b1;
          rlen <= CW'(1);
        end
      end
      if (state == ADDR && rx_valid) bus_addr <= (bus_addr << 8) | AW'(rx_data);
      if (state == WDATA && rx_valid) bus_wdata <= (bus_wdata << 8) | DW'(rx_data);
      if (state_n == BUS && state != BUS) bus_req <= 1'b1;
      // first response byte goes out straight from the ack, the rest drain from rbuf
      if (state == BUS && bus_ack) begin
        bus_req <= 1'b0;
        tx_valid <= 1'b1;
        tx_data <= bus_we ? 8'h4B : bus_rdata[DW-1 -: 8];
        rbuf <= bus_rdata << 8;
        rlen <= bus_we ? CW'(1) : CW'(DATA_BYTES);
      end
      if (tx_hs) begin
        tx_data <= rbuf[DW-1 -: 8];
        rbuf <= rbuf << 8;
        if (tx_done) tx_valid <= 1'b0;
      end
    end
  end
endmodule
